// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port
// between the I-cache miss path and the D-cache miss/writeback path.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_op_wr;

  logic                w_i_pend;
  logic                w_d_pend;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_busy;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

  // Ties go to whoever was not served last; last_grant resets to I.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_d_pend && (!w_i_pend || !r_last_d)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = SERVE_D;
        end else if (w_i_pend) begin
          w_grant_i   = 1'b1;
          w_state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) w_state_nxt = IDLE;
      end
      SERVE_D: begin
        if (pmem_resp) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_op_wr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_addr   <= i_addr;
        r_wdata  <= '0;
        r_op_wr  <= 1'b0;
        r_last_d <= 1'b0;
      end else if (w_grant_d) begin
        r_addr   <= d_addr;
        r_wdata  <= d_wdata;
        r_op_wr  <= d_write;
        r_last_d <= 1'b1;
      end
    end
  end

  // Memory side sees only latched state, never live requester inputs.
  assign w_busy     = (r_state == SERVE_I) || (r_state == SERVE_D);
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;
  assign pmem_read  = w_busy & ~r_op_wr;
  assign pmem_write = w_busy & r_op_wr;

  assign i_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_resp  = (r_state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the I-cache miss path and the D-cache miss/writeback path of the 5-stage LC-3b pipeline.
- Each cache controller presents a line-granular request.
- The arbiter grants one requester at a time using alternating (round-robin) priority.
- It latches the winning request, drives it onto the physical memory port until completion, and routes the response and read line back to the winner.

Parameters:
- ADDR_W, 16, byte address width of both requester ports and the memory port.
- LINE_W, 128, cache line width in bits for rdata and wdata.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_addr  in  ADDR_W  I-cache line address.
- i_read  in  1  I-cache line-read request; held until i_resp.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- i_rdata  out  LINE_W  line returned to the I-cache; valid when i_resp=1.
- d_addr  in  ADDR_W  D-cache line address.
- d_read  in  1  D-cache line-read request; held until d_resp.
- d_write  in  1  D-cache line-writeback request; held until d_resp.
- d_wdata  in  LINE_W  writeback line.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- d_rdata  out  LINE_W  line returned to the D-cache; valid when d_resp=1.
- pmem_addr  out  ADDR_W  physical memory address.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_wdata  out  LINE_W  physical memory write line.
- pmem_rdata  in  LINE_W  physical memory read line.
- pmem_resp  in  1  physical memory completion; one-cycle pulse.

Behaviour:

Reset:
- On a clk edge with reset=1: state=IDLE, last_grant=I, and pmem_read, pmem_write, i_resp and d_resp are 0.
- The latched addr/wdata/op registers are cleared to 0.
- Reset mid-transaction aborts it: the strobes drop on the next cycle, no resp is forwarded, and a later stray pmem_resp seen in IDLE is ignored.

FSM states:
- IDLE, SERVE_I, SERVE_D.

IDLE:
- Samples requests: I is pending if i_read; D is pending if d_read or d_write.
- Only one pending: grant it.
- Both pending: grant the requester that is not last_grant. After reset D wins the first tie.
- On grant: latch addr, op and wdata into internal registers, set last_grant, and move to SERVE_x.
- I requests always latch op=read.
- d_read and d_write both high is illegal; it is treated as write.

SERVE_x:
- pmem_addr, pmem_read, pmem_write and pmem_wdata are driven only from the latched registers and are stable for the entire service.
- Requester inputs are not re-sampled while in SERVE_x, so a requester changing its address mid-service has no effect.

Completion:
- On the cycle pmem_resp=1 in SERVE_x, the matching x_resp=1 combinationally in that same cycle.
- x_rdata = pmem_rdata in that cycle.
- Next state is IDLE.
- The non-granted resp stays 0.

Data outputs:
- i_rdata and d_rdata pass pmem_rdata through continuously.
- They are qualified only by resp.

Latency:
- Grant is registered, so pmem strobes rise 1 cycle after the request is first seen in IDLE.
- There is one mandatory IDLE cycle between services.
- Minimum request-to-resp time is 1 + memory latency.

Requester rules:
- A requester deasserts its request in the cycle after its resp.
- A request still high in IDLE is treated as a new request.
- A request withdrawn during service does not abort it: the memory transaction completes and resp is still pulsed.

Starvation:
- Alternation guarantees each requester waits at most one foreign service.

Strobes:
- pmem_read and pmem_write are never both 1.
- Both are 0 in IDLE.

Test Plan:
- Reset, then i_read=1 with i_addr=0x0040 and memory latency 3:
  - pmem_read rises 1 cycle later with pmem_addr=0x0040.
  - i_resp pulses on the cycle pmem_resp=1.
  - i_rdata equals pmem_rdata, 0x0123...CDEF.
- Reset, then i_read and d_read asserted together (i_addr=0x1000, d_addr=0x2000):
  - D is served first at 0x2000.
  - After one IDLE cycle, I is served at 0x1000.
  - d_resp precedes i_resp, and each pulses exactly once.
- Both requesters held continuously for 4 services:
  - Grant order is D, I, D, I.
  - The pmem_addr sequence alternates accordingly.
- d_write with d_addr=0x3FF0 and d_wdata=0xAAAA…5555:
  - pmem_write=1 with that data, pmem_read=0.
  - d_addr and d_wdata are changed mid-service, but the pmem outputs stay unchanged until pmem_resp.
- Reset pulsed during SERVE_D before pmem_resp:
  - All strobes are 0 the next cycle.
  - A pmem_resp pulse arriving afterwards produces no i_resp or d_resp.
  - A subsequent i_read is served normally.
- pmem_resp pulsed while in IDLE with no requests: no resp output and no state change.
